// File: rtl/trace_cmd_queue_pkg.sv
// Shared trace command definitions and cache address geometry for the trace front end.
package trace_cmd_queue_pkg;

    localparam int unsigned CMD_BITS    = 4;
    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned INDEX_BITS  = 7;
    localparam int unsigned TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [CMD_BITS-1:0] {
        RD_DATA = 4'd0,
        WR_DATA = 4'd1,
        RD_INST = 4'd2,
        SNP_INV = 4'd3,
        SNP_RD  = 4'd4,
        CLEAR   = 4'd8,
        PRINT   = 4'd9
    } trace_cmd_e;

    function automatic logic is_legal_cmd(input logic [CMD_BITS-1:0] cmd);
        logic legal;
        case (cmd)
            RD_DATA, WR_DATA, RD_INST, SNP_INV, SNP_RD, CLEAR, PRINT: legal = 1'b1;
            default:                                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_op_cmd(input logic [CMD_BITS-1:0] cmd);
        return cmd <= CMD_BITS'(SNP_RD);
    endfunction

endpackage

// File: rtl/trace_cmd_queue_addr_split.sv
// Pure combinational tag/index/offset slicer; shared with the cache model.
module addr_split #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TAG_BITS    = 19,
    parameter int unsigned INDEX_BITS  = 7,
    parameter int unsigned OFFSET_BITS = 6
) (
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [TAG_BITS-1:0]    tag_o,
    output logic [INDEX_BITS-1:0]  index_o,
    output logic [OFFSET_BITS-1:0] offset_o
);

    always_comb begin
        tag_o    = addr_i[ADDR_W-1 -: TAG_BITS];
        index_o  = addr_i[OFFSET_BITS +: INDEX_BITS];
        offset_o = addr_i[OFFSET_BITS-1:0];
    end

endmodule

// File: rtl/trace_cmd_queue.sv
// Trace record queue: stores legal commands, issues cache ops by handshake,
// auto-retires clear/print controls in order, and counts dropped illegal codes.
module trace_cmd_queue
    import trace_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = ADDR_BITS,
    parameter int unsigned CMD_W  = CMD_BITS,
    parameter int unsigned ERR_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CMD_W-1:0]         in_cmd,
    input  logic [ADDR_W-1:0]        in_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CMD_W-1:0]         out_cmd,
    output logic [TAG_BITS-1:0]      out_tag,
    output logic [INDEX_BITS-1:0]    out_index,
    output logic [OFFSET_BITS-1:0]   out_offset,
    output logic                     out_snoop,
    output logic                     ctl_clear,
    output logic                     ctl_print,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = CMD_W + ADDR_W;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              clr_q, clr_d, prt_q, prt_d;

    logic [ENT_W-1:0]  head_ent;
    logic [CMD_W-1:0]  head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic              not_empty, head_is_op, head_is_ctl;
    logic              accept, push, drop, pop;

    always_comb begin
        head_ent    = mem_q[rd_q];
        head_cmd    = head_ent[ENT_W-1 -: CMD_W];
        head_addr   = head_ent[ADDR_W-1:0];
        not_empty   = (cnt_q != '0);
        head_is_op  = not_empty && is_op_cmd(CMD_BITS'(head_cmd));
        // Only legal codes are stored, so a non-op head is always clear or print.
        head_is_ctl = not_empty && !is_op_cmd(CMD_BITS'(head_cmd));

        in_ready    = (cnt_q != CNT_W'(DEPTH));
        accept      = in_valid && in_ready;
        push        = accept && is_legal_cmd(CMD_BITS'(in_cmd));
        drop        = accept && !is_legal_cmd(CMD_BITS'(in_cmd));
        pop         = (head_is_op && out_ready) || head_is_ctl;

        wr_d        = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d        = pop  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);

        clr_d       = head_is_ctl && (head_cmd == CMD_W'(CLEAR));
        prt_d       = head_is_ctl && (head_cmd == CMD_W'(PRINT));
        err_pulse_d = drop;
        err_cnt_d   = (drop && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            clr_q       <= 1'b0;
            prt_q       <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            clr_q       <= clr_d;
            prt_q       <= prt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {in_cmd, in_addr};
        end
    end

    addr_split #(
        .ADDR_W      (ADDR_W),
        .TAG_BITS    (TAG_BITS),
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_addr_split (
        .addr_i   (head_addr),
        .tag_o    (out_tag),
        .index_o  (out_index),
        .offset_o (out_offset)
    );

    always_comb begin
        out_valid = head_is_op;
        out_cmd   = head_cmd;
        out_snoop = not_empty && ((head_cmd == CMD_W'(SNP_INV)) || (head_cmd == CMD_W'(SNP_RD)));
        ctl_clear = clr_q;
        ctl_print = prt_q;
        err_pulse = err_pulse_q;
        err_count = err_cnt_q;
        count     = cnt_q;
    end

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Scoreboard bench for trace_cmd_queue: random and directed traffic against a queue-based model.
module tb_trace_cmd_queue;
    import trace_cmd_queue_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TB_ERRW = 4;
    localparam int unsigned ERR_MAX = (1 << TB_ERRW) - 1;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } rec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [3:0]             in_cmd = '0;
    logic [31:0]            in_addr = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [3:0]             out_cmd;
    logic [TAG_BITS-1:0]    out_tag;
    logic [INDEX_BITS-1:0]  out_index;
    logic [OFFSET_BITS-1:0] out_offset;
    logic                   out_snoop;
    logic                   ctl_clear, ctl_print, err_pulse;
    logic [TB_ERRW-1:0]     err_count;
    logic [3:0]             count;

    trace_cmd_queue #(
        .DEPTH (DEPTH),
        .ERR_W (TB_ERRW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cmd    (out_cmd),
        .out_tag    (out_tag),
        .out_index  (out_index),
        .out_offset (out_offset),
        .out_snoop  (out_snoop),
        .ctl_clear  (ctl_clear),
        .ctl_print  (ctl_print),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .count      (count)
    );

    always #5 clk = ~clk;

    rec_t        model[$];
    int unsigned errq[$];
    int unsigned err_model = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_print = 0;
    bit          started = 1'b0;

    function automatic void check(input string name, input longint unsigned got,
                                  input longint unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    function automatic bit legal(input logic [3:0] c);
        return (c <= 4'd4) || (c == 4'd8) || (c == 4'd9);
    endfunction

    // Monitor: pulses refer to entries retired at the previous edge, so consume them first.
    always @(negedge clk) begin
        rec_t        f;
        int unsigned e;
        bit          exp_valid;
        if (started && !rst) begin
            if (ctl_clear || ctl_print) begin
                if (model.size() == 0 || !(model[0].cmd == 4'd8 || model[0].cmd == 4'd9)) begin
                    check("ctl_spurious", 1, 0);
                end else begin
                    f = model.pop_front();
                    check("ctl_clear", ctl_clear, f.cmd == 4'd8);
                    check("ctl_print", ctl_print, f.cmd == 4'd9);
                    if (ctl_print) n_print++;
                end
            end
            if (err_pulse) begin
                if (errq.size() == 0) check("err_spurious", 1, 0);
                else begin
                    e = errq.pop_front();
                    check("err_count", err_count, e);
                end
            end
            check("count", count, model.size());
            check("in_ready", in_ready, model.size() != DEPTH);
            exp_valid = (model.size() != 0) && (model[0].cmd <= 4'd4);
            check("out_valid", out_valid, exp_valid);
            if (out_valid && exp_valid) begin
                f = model[0];
                check("out_cmd", out_cmd, f.cmd);
                check("out_tag", out_tag, f.addr / (32'd1 << (INDEX_BITS + OFFSET_BITS)));
                check("out_index", out_index, (f.addr / (32'd1 << OFFSET_BITS)) % (32'd1 << INDEX_BITS));
                check("out_offset", out_offset, f.addr % (32'd1 << OFFSET_BITS));
                check("out_snoop", out_snoop, (f.cmd == 4'd3) || (f.cmd == 4'd4));
                if (out_ready) void'(model.pop_front());
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a, input logic r);
        bit   acc;
        rec_t rec;
        in_valid  = v;
        in_cmd    = c;
        in_addr   = a;
        out_ready = r;
        acc = v && in_ready;
        @(posedge clk);
        if (acc) begin
            if (legal(c)) begin
                rec.cmd  = c;
                rec.addr = a;
                model.push_back(rec);
            end else begin
                if (err_model != ERR_MAX) err_model++;
                errq.push_back(err_model);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && model.size() != 0; i++) step(1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("drain_empty", model.size(), 0);
    endtask

    function automatic logic [3:0] rand_op();
        return 4'($urandom_range(0, 4));
    endfunction

    function automatic logic [3:0] rand_illegal();
        logic [3:0] c;
        if ($urandom_range(0, 1) == 0) c = 4'($urandom_range(5, 7));
        else                           c = 4'($urandom_range(10, 15));
        return c;
    endfunction

    initial begin
        int unsigned sel;
        logic [3:0]  c;
        #23;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctl", {ctl_clear, ctl_print, err_pulse}, 0);
        check("rst_err_count", err_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;

        // Single op, immediate pop
        step(1'b1, 4'd0, 32'h1000_0040, 1'b1);
        check("t1_count_after_push", count, 1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("t1_count_after_pop", count, 0);

        // Fill to full, reject extra push, one pop frees a slot
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_op(), $urandom, 1'b0);
        check("t2_full_count", count, DEPTH);
        check("t2_full_ready", in_ready, 0);
        step(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("t2_ready_after_pop", in_ready, 1);
        check("t2_count_after_pop", count, DEPTH - 1);
        drain();

        // Control entry waits behind a stalled op
        n_print = 0;
        step(1'b1, 4'd1, 32'hAAAA_5540, 1'b0);
        step(1'b1, 4'd9, 32'h0000_1234, 1'b0);
        step(1'b1, 4'd2, 32'h5555_AA80, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 32'd0, 1'b0);
        check("t3_no_print_yet", n_print, 0);
        drain();
        check("t3_print_once", n_print, 1);

        // Illegal codes dropped and counted, then saturation
        step(1'b1, 4'd5, 32'd0, 1'b1);
        step(1'b1, 4'd7, 32'd0, 1'b1);
        step(1'b1, 4'd15, 32'd0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("t4_err_count", err_count, 3);
        check("t4_count", count, 0);
        for (int i = 0; i < 20; i++) step(1'b1, rand_illegal(), $urandom, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("t4_err_sat", err_count, ERR_MAX);

        // Steady push+pop at half occupancy across pointer wraps
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, rand_op(), $urandom, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, rand_op(), $urandom, 1'b1);
            check("t5_count_steady", count, DEPTH / 2);
        end
        drain();

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) step(1'b1, rand_op(), $urandom, 1'b0);
        step(1'b1, 4'd6, 32'd0, 1'b0);
        in_valid = 1'b1;
        in_cmd   = 4'd1;
        in_addr  = $urandom;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_pulses", {ctl_clear, ctl_print, err_pulse}, 0);
        check("t6_rst_err_count", err_count, 0);
        model.delete();
        errq.delete();
        err_model = 0;
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("t6_post_count", count, 0);
        check("t6_post_valid", out_valid, 0);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      c = rand_op();
            else if (sel < 85) c = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'd9;
            else               c = rand_illegal();
            step($urandom_range(0, 3) != 0, c, $urandom, $urandom_range(0, 3) != 0);
        end
        drain();
        step(1'b0, 4'd0, 32'd0, 1'b1);
        check("final_errq_empty", errq.size(), 0);
        check("final_err_count", err_count, err_model);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
